// File: rtl/rc4_key_search_control.sv
`default_nettype none
// ============================================================================
// rc4_key_search_control : steps candidate keys through init/shuffle/decrypt
//                          sub-FSMs and arbitrates the shared S-memory port.
// Revision 1.0
// ============================================================================
module rc4_key_search_control #(
  parameter int                   KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST  = KEY_WIDTH'(24'h3FFFFF)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_found,
  output logic [KEY_WIDTH-1:0] o_key,
  output logic                 o_start_init,
  output logic                 o_start_shuffle,
  output logic                 o_start_decrypt,
  input  logic                 i_finish_init,
  input  logic                 i_finish_shuffle,
  input  logic                 i_finish_decrypt,
  input  logic                 i_decrypt_valid,
  input  logic                 i_we_init,
  input  logic [7:0]           i_addr_init,
  input  logic [7:0]           i_wdata_init,
  input  logic                 i_we_shuffle,
  input  logic [7:0]           i_addr_shuffle,
  input  logic [7:0]           i_wdata_shuffle,
  input  logic                 i_we_decrypt,
  input  logic [7:0]           i_addr_decrypt,
  input  logic [7:0]           i_wdata_decrypt,
  output logic                 o_s_we,
  output logic [7:0]           o_s_addr,
  output logic [7:0]           o_s_wdata
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_START_INIT = 4'd1,
    S_WAIT_INIT  = 4'd2,
    S_START_SHUF = 4'd3,
    S_WAIT_SHUF  = 4'd4,
    S_START_DEC  = 4'd5,
    S_WAIT_DEC   = 4'd6,
    S_NEXT_KEY   = 4'd7,
    S_DONE_FOUND = 4'd8,
    S_DONE_FAIL  = 4'd9
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [KEY_WIDTH-1:0] r_key;
  logic                 r_done;
  logic                 r_found;
  logic                 w_accept;
  logic                 w_key_last;

  assign w_key_last = (r_key == KEY_LAST);

  always_comb begin
    w_next          = r_state;
    w_accept        = 1'b0;
    o_start_init    = 1'b0;
    o_start_shuffle = 1'b0;
    o_start_decrypt = 1'b0;
    o_s_we          = 1'b0;
    o_s_addr        = 8'h00;
    o_s_wdata       = 8'h00;
    case (r_state)
      S_IDLE, S_DONE_FOUND, S_DONE_FAIL: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = S_START_INIT;
        end
      end
      S_START_INIT: begin
        o_start_init = 1'b1;
        w_next       = S_WAIT_INIT;
      end
      S_WAIT_INIT:  if (i_finish_init) w_next = S_START_SHUF;
      S_START_SHUF: begin
        o_start_shuffle = 1'b1;
        w_next          = S_WAIT_SHUF;
      end
      S_WAIT_SHUF:  if (i_finish_shuffle) w_next = S_START_DEC;
      S_START_DEC: begin
        o_start_decrypt = 1'b1;
        w_next          = S_WAIT_DEC;
      end
      S_WAIT_DEC: begin
        if (i_finish_decrypt) w_next = i_decrypt_valid ? S_DONE_FOUND : S_NEXT_KEY;
      end
      S_NEXT_KEY:   w_next = w_key_last ? S_DONE_FAIL : S_START_INIT;
      default:      w_next = S_IDLE;
    endcase

    // S-memory ownership follows the phase, starting with its START state
    case (r_state)
      S_START_INIT, S_WAIT_INIT: begin
        o_s_we    = i_we_init;
        o_s_addr  = i_addr_init;
        o_s_wdata = i_wdata_init;
      end
      S_START_SHUF, S_WAIT_SHUF: begin
        o_s_we    = i_we_shuffle;
        o_s_addr  = i_addr_shuffle;
        o_s_wdata = i_wdata_shuffle;
      end
      S_START_DEC, S_WAIT_DEC: begin
        o_s_we    = i_we_decrypt;
        o_s_addr  = i_addr_decrypt;
        o_s_wdata = i_wdata_decrypt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_key   <= KEY_START;
      r_done  <= 1'b0;
      r_found <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_key   <= KEY_START;
        r_done  <= 1'b0;
        r_found <= 1'b0;
      end else if (r_state == S_WAIT_DEC && i_finish_decrypt && i_decrypt_valid) begin
        r_done  <= 1'b1;
        r_found <= 1'b1;
      end else if (r_state == S_NEXT_KEY) begin
        // key saturates at KEY_LAST so the increment can never wrap
        if (w_key_last) begin
          r_done  <= 1'b1;
          r_found <= 1'b0;
        end else begin
          r_key <= r_key + KEY_WIDTH'(1);
        end
      end
    end
  end

  assign o_busy  = !(r_state inside {S_IDLE, S_DONE_FOUND, S_DONE_FAIL});
  assign o_done  = r_done;
  assign o_found = r_found;
  assign o_key   = r_key;

endmodule
`default_nettype wire

// File: tb/tb_rc4_key_search_control.sv
`default_nettype none
// Randomized scoreboard bench for rc4_key_search_control: sub-FSM responders,
// stray-pulse injection, and a key-range reference model.
module tb_rc4_key_search_control;
  localparam int KW   = 8;
  localparam int KS_I = 2;
  localparam int KL_I = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, found;
  logic [KW-1:0] key;
  logic          st_init, st_shuf, st_dec;
  logic          finish_init, finish_shuffle, finish_decrypt, decrypt_valid;
  logic          we_init, we_shuffle, we_decrypt;
  logic          s_we;
  logic [7:0]    s_addr, s_wdata;

  logic fi_r, fs_r, fd_r, dv_r;
  logic si_r, ss_r, sd_r, dv_rand;

  assign finish_init    = fi_r | si_r;
  assign finish_shuffle = fs_r | ss_r;
  assign finish_decrypt = fd_r | sd_r;
  assign decrypt_valid  = fd_r ? dv_r : dv_rand;

  always #5 clk = ~clk;

  rc4_key_search_control #(
    .KEY_WIDTH (KW),
    .KEY_START (KW'(KS_I)),
    .KEY_LAST  (KW'(KL_I))
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_start          (start),
    .o_busy           (busy),
    .o_done           (done),
    .o_found          (found),
    .o_key            (key),
    .o_start_init     (st_init),
    .o_start_shuffle  (st_shuf),
    .o_start_decrypt  (st_dec),
    .i_finish_init    (finish_init),
    .i_finish_shuffle (finish_shuffle),
    .i_finish_decrypt (finish_decrypt),
    .i_decrypt_valid  (decrypt_valid),
    .i_we_init        (we_init),
    .i_addr_init      (8'h11),
    .i_wdata_init     (8'hA1),
    .i_we_shuffle     (we_shuffle),
    .i_addr_shuffle   (8'h22),
    .i_wdata_shuffle  (8'hA2),
    .i_we_decrypt     (we_decrypt),
    .i_addr_decrypt   (8'h33),
    .i_wdata_decrypt  (8'hA3),
    .o_s_we           (s_we),
    .o_s_addr         (s_addr),
    .o_s_wdata        (s_wdata)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int tgt      = -1;
  int ph       = 0;   // 0 none, 1 init, 2 shuffle, 3 decrypt
  int cnt_sh   = 0;
  int cnt_dec  = 0;
  int q_key[$];
  int q_last[$];
  bit q_found[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_reset_vals();
    chk("reset_outputs", {9'd0, busy, done, found, st_init, st_shuf, st_dec, s_we, s_addr, s_wdata}, 32'd0);
    chk("reset_key", key, KS_I);
  endtask

  // Sub-FSM models: finish 2..6 cycles after their start pulse
  initial begin
    fi_r = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && st_init) begin
        repeat ($urandom_range(2, 6)) @(negedge clk);
        if (rst_n) begin fi_r = 1'b1; @(negedge clk); fi_r = 1'b0; end
      end
    end
  end

  initial begin
    fs_r = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && st_shuf) begin
        repeat ($urandom_range(2, 6)) @(negedge clk);
        if (rst_n) begin fs_r = 1'b1; @(negedge clk); fs_r = 1'b0; end
      end
    end
  end

  initial begin
    fd_r = 1'b0;
    dv_r = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && st_dec) begin
        repeat ($urandom_range(2, 6)) @(negedge clk);
        if (rst_n) begin
          fd_r = 1'b1;
          dv_r = (int'(key) == tgt);
          @(negedge clk);
          fd_r = 1'b0;
        end
      end
    end
  end

  // Stray finish pulses for phases not currently active, plus random mem requests
  initial begin
    int w;
    si_r = 1'b0; ss_r = 1'b0; sd_r = 1'b0; dv_rand = 1'b0;
    we_init = 1'b0; we_shuffle = 1'b0; we_decrypt = 1'b0;
    forever begin
      @(negedge clk);
      si_r = 1'b0; ss_r = 1'b0; sd_r = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        w = $urandom_range(1, 3);
        if (w != ph) begin
          if (w == 1) si_r = 1'b1;
          else if (w == 2) ss_r = 1'b1;
          else sd_r = 1'b1;
        end
      end
      dv_rand    = 1'($urandom_range(0, 1));
      we_init    = 1'($urandom_range(0, 1));
      we_shuffle = 1'($urandom_range(0, 1));
      we_decrypt = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: pops scoreboard entries on start_init and on done rising
  logic       prev_done = 1'b0;
  int         m_k, m_l;
  bit         m_f;
  logic [16:0] m_exp;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      ph        = 0;
      prev_done = 1'b0;
    end else begin
      if (st_init) begin
        if (q_key.size() == 0) chk("unexpected_start_init", st_init, 0);
        else begin
          m_k = q_key.pop_front();
          chk("key_at_start_init", {busy, key}, {1'b1, KW'(m_k)});
        end
      end
      if (st_shuf) begin
        cnt_sh++;
        chk("shuffle_after_finish_init", finish_init, 1);
      end
      if (st_dec) begin
        cnt_dec++;
        chk("decrypt_after_finish_shuffle", finish_shuffle, 1);
      end
      if (done && !prev_done) begin
        if (q_found.size() == 0) chk("unexpected_done", done, 0);
        else begin
          m_f = q_found.pop_front();
          m_l = q_last.pop_front();
          chk("result_found", found, m_f);
          chk("result_key", key, m_l);
          chk("busy_at_done", busy, 0);
        end
      end
      prev_done = done;

      if (!busy) ph = 0;
      else if (st_init) ph = 1;
      else if (st_shuf) ph = 2;
      else if (st_dec) ph = 3;
      else if (ph == 3 && finish_decrypt) ph = 0;

      case (ph)
        1:       m_exp = {we_init,    8'h11, 8'hA1};
        2:       m_exp = {we_shuffle, 8'h22, 8'hA2};
        3:       m_exp = {we_decrypt, 8'h33, 8'hA3};
        default: m_exp = 17'd0;
      endcase
      chk("s_mem_mux", {s_we, s_addr, s_wdata}, m_exp);
    end
  end

  task automatic run_search(input int t);
    bit hit;
    int last;
    int cyc;
    hit  = (t >= KS_I) && (t <= KL_I);
    last = hit ? t : KL_I;
    tgt  = t;
    for (int k = KS_I; k <= last; k++) q_key.push_back(k);
    q_found.push_back(hit);
    q_last.push_back(last);
    cnt_sh  = 0;
    cnt_dec = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("done_cleared_by_start", done, 0);
    chk("busy_after_start", busy, 1);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      start = busy && ($urandom_range(0, 15) == 0);
      cyc++;
    end
    start = 1'b0;
    chk("done_timeout", done, 1);
    chk("shuffle_pulse_count", cnt_sh, last - KS_I + 1);
    chk("decrypt_pulse_count", cnt_dec, last - KS_I + 1);
    repeat (3) @(negedge clk);
    chk("done_held", {done, busy}, 2'b10);
  endtask

  task automatic mid_reset();
    int cyc;
    tgt = -1;
    for (int k = KS_I; k <= KL_I; k++) q_key.push_back(k);
    q_found.push_back(1'b0);
    q_last.push_back(KL_I);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!st_dec && cyc < 500) begin @(negedge clk); cyc++; end
    chk("reach_start_decrypt", st_dec, 1);
    @(negedge clk);
    chk("busy_in_wait_decrypt", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    q_key.delete();
    q_found.delete();
    q_last.delete();
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
    end
    chk_reset_vals();
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals();
    @(negedge clk);

    run_search(KS_I);        // first key decrypts
    run_search(KS_I + 5);    // several failed keys, then success
    run_search(KL_I);        // success on the last key of the range
    run_search(-1);          // range exhausted
    run_search(KS_I + 1);    // restart after exhaustion
    mid_reset();
    run_search(KS_I + 2);
    repeat (6) run_search($urandom_range(0, KL_I + 3));

    chk("scoreboard_drained", q_key.size() + q_found.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
